// File: rtl/sm4_pkg.sv
// Shared SM4 definitions: S-box table, round-function helpers and the core FSM state type.
package sm4_pkg;

    localparam int SM4_ROUNDS = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Entry 0 is the most significant byte of the concatenation.
    localparam logic [0:255][7:0] SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    function automatic logic [31:0] sbox32(input logic [31:0] a);
        return {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
    endfunction

    function automatic logic [31:0] lin_l(input logic [31:0] b);
        return b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]}
                 ^ {b[13:0], b[31:14]} ^ {b[7:0],  b[31:8]};
    endfunction

endpackage

// File: rtl/sm4_round.sv
// One SM4 round: X4 = X0 ^ L(tau(X1 ^ X2 ^ X3 ^ rk)). Purely combinational.
module sm4_round
    import sm4_pkg::*;
(
    input  logic [31:0] x0,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    input  logic [31:0] x3,
    input  logic [31:0] rk,
    output logic [31:0] x4
);

    assign x4 = x0 ^ lin_l(sbox32(x1 ^ x2 ^ x3 ^ rk));

endmodule

// File: rtl/sm4_iter_core.sv
// Iterative SM4 encrypt/decrypt core, ROUNDS_PER_CYCLE chained rounds per clock.
// Define SM4_KEY_LATCH_EN to capture RK_ALL_i at accept instead of reading it live.
module sm4_iter_core
    import sm4_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic          CLK_i,
    input  logic          RST_i,
    input  logic [127:0]  DAT_i,
    input  logic          MODE_i,
    input  logic [1023:0] RK_ALL_i,
    input  logic          DAT_VALID_i,
    output logic          DAT_READY_o,
    output logic [127:0]  DAT_o,
    output logic          OUT_VALID_o,
    input  logic          OUT_READY_i
);

    localparam int RUN_CYCLES = SM4_ROUNDS / ROUNDS_PER_CYCLE;

    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
          ROUNDS_PER_CYCLE == 4 || ROUNDS_PER_CYCLE == 8) ||
        RUN_CYCLES * ROUNDS_PER_CYCLE != SM4_ROUNDS) begin : g_bad_rounds_per_cycle
        $error("sm4_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    state_t         state, state_nxt;
    logic [5:0]     rnd_cnt;
    logic [127:0]   x_q;
    logic           mode_q;
    logic [127:0]   dat_q;
    logic [1023:0]  key_src;
    logic [127:0]   chain [ROUNDS_PER_CYCLE+1];
    logic           accept;
    logic           rounds_done;

    assign accept      = DAT_VALID_i & DAT_READY_o;
    assign rounds_done = (rnd_cnt == 6'(SM4_ROUNDS));

`ifdef SM4_KEY_LATCH_EN
    logic [1023:0] key_q;

    // NOTE: pure datapath register with no reset; it is always written at accept before use.
    always_ff @(posedge CLK_i) begin
        if (accept) key_q <= RK_ALL_i;
    end

    assign key_src = key_q;
`else
    assign key_src = RK_ALL_i;
`endif

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every output of this block is defaulted first so no latch is inferred.
    always_comb begin
        state_nxt   = state;
        DAT_READY_o = 1'b0;
        OUT_VALID_o = 1'b0;
        case (state)
            IDLE: begin
                DAT_READY_o = 1'b1;
                if (DAT_VALID_i) state_nxt = RUN;
            end
            RUN: begin
                if (rounds_done) state_nxt = DONE;
            end
            DONE: begin
                OUT_VALID_o = 1'b1;
                DAT_READY_o = OUT_READY_i;
                if (OUT_READY_i) state_nxt = DAT_VALID_i ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign chain[0] = x_q;

    for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : g_round
        logic [4:0]  rnd_idx;
        logic [4:0]  key_idx;
        logic [31:0] x_new;

        // Decrypt walks the keys backwards: 31 - r is the bitwise complement in 5 bits.
        assign rnd_idx = rnd_cnt[4:0] + 5'(j);
        assign key_idx = mode_q ? ~rnd_idx : rnd_idx;

        sm4_round u_round (
            .x0 (chain[j][127:96]),
            .x1 (chain[j][95:64]),
            .x2 (chain[j][63:32]),
            .x3 (chain[j][31:0]),
            .rk (key_src[{key_idx, 5'd0} +: 32]),
            .x4 (x_new)
        );

        assign chain[j+1] = {chain[j][95:0], x_new};
    end

    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            x_q     <= '0;
            rnd_cnt <= '0;
            mode_q  <= 1'b0;
            dat_q   <= '0;
        end else if (accept) begin
            x_q     <= DAT_i;
            mode_q  <= MODE_i;
            rnd_cnt <= '0;
        end else if (state == RUN) begin
            if (!rounds_done) begin
                x_q     <= chain[ROUNDS_PER_CYCLE];
                rnd_cnt <= rnd_cnt + 6'(ROUNDS_PER_CYCLE);
            end else begin
                // x_q holds {X32,X33,X34,X35}; the output is the word-reversed block.
                dat_q <= {x_q[31:0], x_q[63:32], x_q[95:64], x_q[127:96]};
            end
        end
    end

    assign DAT_o = dat_q;

endmodule
